fp_add_arbiter: RTL and testbench

Shares one combinational fp_adder instance among NREQ requesters using round-robin arbitration. Each requester asks for a single-precision a+b or a-b. Subtraction is done by flipping the sign of b, the same trick used to build a subtractor from fp_adder. The block registers operands, drives the shared adder, captures the sum and returns it with the requester ID over a valid/ready response channel.

---
 rtl/fp_add_arbiter_pkg.sv | 11 +
 rtl/fp_add_arbiter_if.sv | 32 +++
 rtl/fp_add_arbiter_rr_arbiter.sv | 28 ++
 rtl/fp_add_arbiter.sv | 103 ++++++++++
 tb/tb_fp_add_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_add_arbiter_pkg.sv
// Shared types and constants for the round-robin fp_adder arbiter.
package fp_arb_pkg;
  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] SIGN_MASK = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    RESP    = 2'd2
  } state_t;
endpackage

// File: rtl/fp_add_arbiter_if.sv
// Request, response and shared-adder signals of fp_add_arbiter, bundled with modports.
interface fp_add_arbiter_if #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
);
  import fp_arb_pkg::*;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // req_ready is one-hot or zero; rsp_valid holds with stable rsp_id/rsp_s until rsp_ready.
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*FP_W-1:0] req_a;
  logic [NREQ*FP_W-1:0] req_b;
  logic [NREQ-1:0]      req_sub;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [FP_W-1:0]      rsp_s;
  logic [FP_W-1:0]      fpa_a;
  logic [FP_W-1:0]      fpa_b;
  logic [FP_W-1:0]      fpa_s;

  modport slave (
    input  req_valid, req_a, req_b, req_sub, rsp_ready, fpa_s,
    output req_ready, rsp_valid, rsp_id, rsp_s, fpa_a, fpa_b
  );

  modport master (
    output req_valid, req_a, req_b, req_sub, rsp_ready, fpa_s,
    input  req_ready, rsp_valid, rsp_id, rsp_s, fpa_a, fpa_b
  );
endinterface

// File: rtl/fp_add_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr+1, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_idx,
  output logic            any_valid
);
  int unsigned idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!any_valid && req[idx]) begin
        any_valid      = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = ID_W'(idx);
      end
    end
  end
endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin sharing of one external combinational fp_adder among NREQ requesters.
// Optional macro FP_ADD_ARB_STATS_EN adds a 16-bit completed-response counter output.
module fp_add_arbiter
  import fp_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  fp_add_arbiter_if.slave bus,
`ifdef FP_ADD_ARB_STATS_EN
  output logic [15:0]    op_count,
`endif
  output state_t         state_dbg
);
  state_t          state, state_nxt;
  logic [ID_W-1:0] ptr, id_r, grant_idx;
  logic [NREQ-1:0] grant;
  logic            any_valid;
  logic [FP_W-1:0] a_r, b_r, a_sel, b_sel;
  logic [FP_W-1:0] rsp_s_r;
  logic [ID_W-1:0] rsp_id_r;
  logic            rsp_valid_r;

  rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_rr (
    .req       (bus.req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  // Subtraction is addition with the sign of b inverted.
  always_comb begin
    a_sel = bus.req_a[int'(grant_idx)*FP_W +: FP_W];
    b_sel = bus.req_b[int'(grant_idx)*FP_W +: FP_W] ^
            (bus.req_sub[grant_idx] ? SIGN_MASK : '0);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = COMPUTE;
      COMPUTE: state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= ID_W'(NREQ - 1);
      a_r         <= '0;
      b_r         <= '0;
      id_r        <= '0;
      rsp_s_r     <= '0;
      rsp_id_r    <= '0;
      rsp_valid_r <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (any_valid) begin
            a_r  <= a_sel;
            b_r  <= b_sel;
            id_r <= grant_idx;
            ptr  <= grant_idx;
          end
        end
        COMPUTE: begin
          rsp_s_r     <= bus.fpa_s;
          rsp_id_r    <= id_r;
          rsp_valid_r <= 1'b1;
        end
        RESP: begin
          if (bus.rsp_ready) rsp_valid_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE) ? grant : '0;
  assign bus.fpa_a     = a_r;
  assign bus.fpa_b     = b_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_s     = rsp_s_r;
  assign state_dbg     = state;

`ifdef FP_ADD_ARB_STATS_EN
  logic [15:0] op_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)                         op_cnt_q <= '0;
    else if (rsp_valid_r && bus.rsp_ready) op_cnt_q <= op_cnt_q + 16'd1;
  end

  assign op_count = op_cnt_q;
`endif
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: behavioural stand-in adder, scoreboard of granted requests.
module tb_fp_add_arbiter;
  import fp_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_add_arbiter_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();
  state_t state_dbg;
`ifdef FP_ADD_ARB_STATS_EN
  logic [15:0] op_count;
`endif

  fp_add_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
`ifdef FP_ADD_ARB_STATS_EN
    .op_count  (op_count),
`endif
    .state_dbg (state_dbg)
  );

  int errors = 0;
  int checks = 0;
  logic [ID_W+31:0] exp_q[$];
  logic [ID_W+31:0] mon_exp;

  // Single-precision add for normal operands via double arithmetic, truncating.
  function automatic real sp_to_real(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:23] == 8'd0) return 0.0;
    d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real_to_sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:52] < 11'd897) return 32'd0;
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_add_model(input logic [31:0] a, input logic [31:0] b);
    return real_to_sp(sp_to_real(a) + sp_to_real(b));
  endfunction

  function automatic logic [31:0] rand_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
  endfunction

  assign bus.fpa_s = fp_add_model(bus.fpa_a, bus.fpa_b);

  // Monitor: push expected results on request handshakes, compare on response handshakes.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      checks++;
      if (((bus.req_ready & (bus.req_ready - 1'b1)) != '0) || ((bus.req_ready & ~bus.req_valid) != '0)) begin
        errors++;
        $display("FAIL grant_onehot: req_ready=%b req_valid=%b", bus.req_ready, bus.req_valid);
      end
      for (int k = 0; k < NREQ; k++) begin
        if (bus.req_valid[k] && bus.req_ready[k])
          exp_q.push_back({ID_W'(k), fp_add_model(bus.req_a[k*32 +: 32],
                           bus.req_b[k*32 +: 32] ^ (bus.req_sub[k] ? SIGN_MASK : 32'd0))});
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: id=%0d s=%h with empty queue", bus.rsp_id, bus.rsp_s);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({bus.rsp_id, bus.rsp_s} !== mon_exp) begin
            errors++;
            $display("FAIL rsp_data: got id=%0d s=%h expected id=%0d s=%h",
                     bus.rsp_id, bus.rsp_s, mon_exp[ID_W+31:32], mon_exp[31:0]);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int k, input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.req_valid[k]       = 1'b1;
    bus.req_a[k*32 +: 32]  = a;
    bus.req_b[k*32 +: 32]  = b;
    bus.req_sub[k]         = s;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && state_dbg == IDLE && !bus.rsp_valid) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: queue=%0d state=%0d rsp_valid=%b", exp_q.size(), state_dbg, bus.rsp_valid);
    end
    tick();
  endtask

  task automatic test_reset();
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_sub = '0;
    bus.rsp_ready = 1'b0;
    apply_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_s, bus.req_ready, bus.fpa_a, bus.fpa_b} !== '0 || state_dbg !== IDLE) begin
      errors++;
      $display("FAIL reset_values: rsp_valid=%b id=%0d s=%h ready=%b fpa_a=%h fpa_b=%h state=%0d",
               bus.rsp_valid, bus.rsp_id, bus.rsp_s, bus.req_ready, bus.fpa_a, bus.fpa_b, state_dbg);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    bus.rsp_ready = 1'b1;
    drive_req(0, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++; $display("FAIL add_grant: req_ready=%b expected 0001", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    checks++;
    if (state_dbg !== COMPUTE || bus.fpa_a !== 32'h3F80_0000 || bus.fpa_b !== 32'h4000_0000 || bus.req_ready !== '0) begin
      errors++; $display("FAIL add_compute: state=%0d fpa_a=%h fpa_b=%h ready=%b", state_dbg, bus.fpa_a, bus.fpa_b, bus.req_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_s !== 32'h4040_0000) begin
      errors++; $display("FAIL add_rsp: valid=%b id=%0d s=%h expected 1 0 40400000", bus.rsp_valid, bus.rsp_id, bus.rsp_s);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0 || state_dbg !== IDLE) begin
      errors++; $display("FAIL add_release: valid=%b state=%0d expected 0 IDLE", bus.rsp_valid, state_dbg);
    end
    tick();
  endtask

  task automatic test_sub();
    bus.rsp_ready = 1'b1;
    drive_req(2, 32'h4040_0000, 32'h3F80_0000, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      errors++; $display("FAIL sub_grant: req_ready=%b expected 0100", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    checks++;
    if (bus.fpa_b !== 32'hBF80_0000 || bus.fpa_a !== 32'h4040_0000) begin
      errors++; $display("FAIL sub_operands: fpa_a=%h fpa_b=%h expected 40400000 BF800000", bus.fpa_a, bus.fpa_b);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_s !== 32'h4000_0000) begin
      errors++; $display("FAIL sub_rsp: valid=%b id=%0d s=%h expected 1 2 40000000", bus.rsp_valid, bus.rsp_id, bus.rsp_s);
    end
    wait_idle();
  endtask

  task automatic test_round_robin();
    int n = 0;
    int last = 0;
    int g;
    apply_reset();
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < NREQ; k++) drive_req(k, rand_fp(), rand_fp(), 1'($urandom_range(0, 1)));
    for (int c = 0; c < 40 && n < 6; c++) begin
      @(negedge clk);
      g = -1;
      for (int k = 0; k < NREQ; k++) if (bus.req_ready[k]) g = k;
      if (g >= 0) begin
        checks++;
        if (g != n % NREQ || (n > 0 && c - last != 3)) begin
          errors++; $display("FAIL rr_order: grant %0d was req %0d after %0d cycles, expected req %0d after 3", n, g, c - last, n % NREQ);
        end
        last = c;
        n++;
      end
      tick();
      if (g >= 0) drive_req(g, rand_fp(), rand_fp(), 1'($urandom_range(0, 1)));
      if (n == 6) bus.req_valid = '0;
    end
    checks++;
    if (n != 6) begin
      errors++; $display("FAIL rr_count: saw %0d grants, expected 6", n);
    end
    bus.req_valid = '0;
    wait_idle();
  endtask

  task automatic test_backpressure();
    logic [31:0] a3, b3, exp_s;
    a3 = rand_fp();
    b3 = rand_fp();
    exp_s = fp_add_model(a3, b3 ^ SIGN_MASK);
    bus.rsp_ready = 1'b0;
    drive_req(1, rand_fp(), rand_fp(), 1'b0);
    drive_req(3, a3, b3, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b1000) begin
      errors++; $display("FAIL bp_grant: req_ready=%b expected 1000", bus.req_ready);
    end
    tick();
    bus.req_valid[3] = 1'b0;
    @(negedge clk);
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd3 || bus.rsp_s !== exp_s || bus.req_ready !== '0) begin
        errors++; $display("FAIL bp_hold: cycle %0d valid=%b id=%0d s=%h ready=%b expected 1 3 %h 0000",
                           c, bus.rsp_valid, bus.rsp_id, bus.rsp_s, bus.req_ready, exp_s);
      end
      tick();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0010 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL bp_next_grant: req_ready=%b rsp_valid=%b expected 0010 0", bus.req_ready, bus.rsp_valid);
    end
    tick();
    bus.req_valid = '0;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    bus.rsp_ready = 1'b1;
    drive_req(2, rand_fp(), rand_fp(), 1'b0);
    @(negedge clk);
    tick();
    bus.req_valid = '0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (state_dbg !== COMPUTE) begin
      errors++; $display("FAIL rstmid_state: state=%0d expected COMPUTE", state_dbg);
    end
    tick();
    rst_n = 1'b1;
    drive_req(0, rand_fp(), rand_fp(), 1'b0);
    drive_req(3, rand_fp(), rand_fp(), 1'b1);
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0 || state_dbg !== IDLE || bus.req_ready !== 4'b0001) begin
      errors++; $display("FAIL rstmid_after: valid=%b state=%0d ready=%b expected 0 IDLE 0001", bus.rsp_valid, state_dbg, bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    wait_idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 200; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        bus.req_valid[k]      = 1'($urandom_range(0, 1));
        bus.req_a[k*32 +: 32] = rand_fp();
        bus.req_b[k*32 +: 32] = rand_fp();
        bus.req_sub[k]        = 1'($urandom_range(0, 1));
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    wait_idle();
  endtask

`ifdef FP_ADD_ARB_STATS_EN
  task automatic test_stats();
    apply_reset();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (op_count !== 16'd0) begin
      errors++; $display("FAIL stats_reset: op_count=%0d expected 0", op_count);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive_req(i, rand_fp(), rand_fp(), 1'b0);
      @(negedge clk);
      tick();
      bus.req_valid = '0;
      wait_idle();
    end
    @(negedge clk);
    checks++;
    if (op_count !== 16'd3) begin
      errors++; $display("FAIL stats_count: op_count=%0d expected 3", op_count);
    end
    force dut.op_cnt_q = 16'hFFFF;
    #1;
    release dut.op_cnt_q;
    tick();
    drive_req(1, rand_fp(), rand_fp(), 1'b0);
    @(negedge clk);
    tick();
    bus.req_valid = '0;
    wait_idle();
    @(negedge clk);
    checks++;
    if (op_count !== 16'd0) begin
      errors++; $display("FAIL stats_wrap: op_count=%h expected 0000", op_count);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef FP_ADD_ARB_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
